// File: rtl/stream_rr_arbiter.sv
// Four-input packet-granular round-robin stream merger with a single registered output stage.
// Arbitration is combinational in IDLE; a grant is held in LOCKED until the packet's last beat moves.
module stream_rr_arbiter #(
  parameter int DATA_WIDTH = 128,
  parameter int PORTS      = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [PORTS-1:0]            dataIn_valid,
  output logic [PORTS-1:0]            dataIn_ready,
  input  logic [PORTS*DATA_WIDTH-1:0] dataIn_payload,
  input  logic [PORTS-1:0]            dataIn_last,
  output logic                        dataOut_valid,
  input  logic                        dataOut_ready,
  output logic [DATA_WIDTH-1:0]       dataOut_payload,
  output logic                        dataOut_last,
  output logic [1:0]                  dataOut_source
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t                  state, state_nxt;
  logic [1:0]              ptr, ptr_nxt;
  logic [1:0]              gnt_idx, gnt_idx_nxt;
  logic [2:0]              pick;
  logic [1:0]              winner;
  logic                    any_valid;
  logic [1:0]              grantee;
  logic                    grant_ok;
  logic                    accept;
  logic                    in_xfer;
  logic                    sel_last;
  logic [DATA_WIDTH-1:0]   sel_payload;

  logic                    vld_p0;
  logic                    last_p0;
  logic [1:0]              src_p0;
  logic [DATA_WIDTH-1:0]   data_p0;

  // Returns {found, index}: first set bit of vld searching base, base+1, ... with 2-bit wrap.
  function automatic logic [2:0] rr_pick(input logic [3:0] vld, input logic [1:0] base);
    logic [2:0] res;
    logic [1:0] idx;
    res = {1'b0, base};
    for (int k = 3; k >= 0; k--) begin
      idx = base + 2'(k);
      if (vld[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    pick        = rr_pick(dataIn_valid, ptr);
    any_valid   = pick[2];
    winner      = pick[1:0];
    grantee     = (state == LOCKED) ? gnt_idx : winner;
    grant_ok    = (state == LOCKED) || any_valid;
    accept      = !vld_p0 || dataOut_ready;
    dataIn_ready = (grant_ok && accept) ? (PORTS'(1) << grantee) : '0;
    in_xfer     = |(dataIn_valid & dataIn_ready);
    sel_last    = dataIn_last[grantee];
    sel_payload = dataIn_payload[grantee*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    state_nxt   = state;
    gnt_idx_nxt = gnt_idx;
    ptr_nxt     = ptr;
    case (state)
      IDLE: begin
        if (in_xfer && !sel_last) begin
          state_nxt   = LOCKED;
          gnt_idx_nxt = winner;
        end
      end
      LOCKED: begin
        if (in_xfer && sel_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A finished packet moves priority to the port after the one just served.
    if (in_xfer && sel_last) ptr_nxt = grantee + 2'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      ptr     <= 2'd0;
      gnt_idx <= 2'd0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      gnt_idx <= gnt_idx_nxt;
    end
  end

  // Output stage p0: control fields are reset, payload is not.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
      src_p0  <= 2'd0;
    end else begin
      if (accept) vld_p0 <= in_xfer;
      if (in_xfer) begin
        last_p0 <= sel_last;
        src_p0  <= grantee;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_xfer) data_p0 <= sel_payload;
  end

  assign dataOut_valid   = vld_p0;
  assign dataOut_last    = last_p0;
  assign dataOut_source  = src_p0;
  assign dataOut_payload = data_p0;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Scoreboard bench for stream_rr_arbiter: directed packet vectors with hand-ordered expected
// output beats, plus a randomized phase checked per source port.
module tb_stream_rr_arbiter;
  localparam int DW = 128;

  typedef struct packed { logic bubble; logic last; logic [DW-1:0] data; } beat_t;
  typedef struct packed { logic [1:0] src; logic last; logic [DW-1:0] data; } exp_t;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [3:0]      dataIn_valid = '0;
  logic [3:0]      dataIn_ready;
  logic [4*DW-1:0] dataIn_payload = '0;
  logic [3:0]      dataIn_last = '0;
  logic            dataOut_valid;
  logic            dataOut_ready = 1'b1;
  logic [DW-1:0]   dataOut_payload;
  logic            dataOut_last;
  logic [1:0]      dataOut_source;

  always #5 clk = ~clk;

  stream_rr_arbiter #(.DATA_WIDTH(DW), .PORTS(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .dataIn_valid(dataIn_valid), .dataIn_ready(dataIn_ready),
    .dataIn_payload(dataIn_payload), .dataIn_last(dataIn_last),
    .dataOut_valid(dataOut_valid), .dataOut_ready(dataOut_ready),
    .dataOut_payload(dataOut_payload), .dataOut_last(dataOut_last),
    .dataOut_source(dataOut_source)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  beat_t pq[4][$];
  exp_t  exp_q[$];
  exp_t  exp_port[4][$];
  logic  rdy_q[$];
  int    out_cyc[$];
  bit    shown[4];
  logic [3:0] xfer_s = '0;
  bit    rand_mode = 1'b0;
  int    phase = 0;
  int    viol = 0;
  bit    hold_pending = 1'b0;
  logic [DW-1:0] hold_data;
  logic  hold_last;
  logic [1:0] hold_src;
  bit    in_pkt = 1'b0;
  logic [1:0] pkt_src;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_d(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int p, input int n);
    return {32'hA5A50000 + 32'(n), 32'(p), ~32'(n), 32'(p * 16 + n) ^ 32'h0F0F0000};
  endfunction

  task automatic send(input int p, input logic [DW-1:0] d, input logic l);
    beat_t b;
    b.bubble = 1'b0; b.last = l; b.data = d;
    pq[p].push_back(b);
  endtask

  task automatic gap(input int p);
    beat_t b;
    b.bubble = 1'b1; b.last = 1'b0; b.data = '0;
    pq[p].push_back(b);
  endtask

  task automatic expect_beat(input logic [1:0] s, input logic [DW-1:0] d, input logic l);
    exp_t e;
    e.src = s; e.last = l; e.data = d;
    exp_q.push_back(e);
  endtask

  function automatic bit busy();
    bit b;
    b = dataOut_valid || (exp_q.size() != 0);
    for (int p = 0; p < 4; p++)
      if (pq[p].size() != 0 || exp_port[p].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic wait_drain(input string name);
    int budget;
    budget = 5000;
    while (busy() && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    n_cmp++;
    if (budget == 0) begin
      n_err++;
      $display("FAIL %s_drain: got timeout with %0d beats outstanding, expected all delivered", name, exp_q.size());
    end
    @(posedge clk);
  endtask

  // Input driver: beats advance after a handshake; a bubble entry is shown for one cycle.
  always @(negedge clk) xfer_s = dataIn_valid & dataIn_ready;

  always begin
    @(posedge clk);
    #1;
    for (int p = 0; p < 4; p++) begin
      if (pq[p].size() > 0 && shown[p]) begin
        if (pq[p][0].bubble || xfer_s[p]) void'(pq[p].pop_front());
      end
      if (pq[p].size() > 0) begin
        shown[p] = 1'b1;
        dataIn_valid[p] = !pq[p][0].bubble;
        dataIn_last[p] = pq[p][0].last;
        dataIn_payload[p*DW +: DW] = pq[p][0].data;
      end else begin
        shown[p] = 1'b0;
        dataIn_valid[p] = 1'b0;
        dataIn_last[p] = 1'b0;
      end
    end
    if (rdy_q.size() > 0) dataOut_ready = rdy_q.pop_front();
    else if (rand_mode) dataOut_ready = ($urandom_range(0, 3) != 0);
    else dataOut_ready = 1'b1;
  end

  // Monitor: scoreboard pops on every output handshake plus per-cycle interface properties.
  always @(negedge clk) begin
    if (!reset_n) begin
      hold_pending = 1'b0;
      in_pkt = 1'b0;
    end else begin
      n_cmp++;
      if (!$onehot0(dataIn_ready)) begin
        n_err++;
        $display("FAIL ready_onehot: got %b, expected at most one bit set", dataIn_ready);
      end
      if (dataIn_ready != 4'b0000) check("ready_when_stalled", 32'(dataOut_valid && !dataOut_ready), 32'd0);
      if (hold_pending) begin
        check("hold_valid", 32'(dataOut_valid), 32'd1);
        check_d("hold_payload", dataOut_payload, hold_data);
        check("hold_last", 32'(dataOut_last), 32'(hold_last));
        check("hold_source", 32'(dataOut_source), 32'(hold_src));
      end
      if (phase == 2 && pq[2].size() != 0 && dataIn_ready[0]) viol++;
      if (dataOut_valid && dataOut_ready) begin
        exp_t e;
        out_cyc.push_back(cyc);
        if (in_pkt) check("no_interleave", 32'(dataOut_source), 32'(pkt_src));
        in_pkt = !dataOut_last;
        pkt_src = dataOut_source;
        if (rand_mode ? (exp_port[dataOut_source].size() == 0) : (exp_q.size() == 0)) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_beat: got source %0d payload %h, expected no beat", dataOut_source, dataOut_payload);
        end else begin
          e = rand_mode ? exp_port[dataOut_source].pop_front() : exp_q.pop_front();
          check("out_source", 32'(dataOut_source), 32'(e.src));
          check_d("out_payload", dataOut_payload, e.data);
          check("out_last", 32'(dataOut_last), 32'(e.last));
        end
      end
      hold_pending = dataOut_valid && !dataOut_ready;
      hold_data = dataOut_payload;
      hold_last = dataOut_last;
      hold_src = dataOut_source;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq;
    int len;
    exp_t e;
    beat_t b;
    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_valid", 32'(dataOut_valid), 32'd0);
    check("rst_last", 32'(dataOut_last), 32'd0);
    check("rst_source", 32'(dataOut_source), 32'd0);
    check("rst_ready", 32'(dataIn_ready), 32'd0);
    reset_n = 1'b1;
    @(posedge clk);

    // All four ports with single-beat packets, port 0 twice: 0,1,2,3,0 back to back
    phase = 1;
    out_cyc.delete();
    for (int p = 0; p < 4; p++) send(p, mk(p, 0), 1'b1);
    send(0, mk(0, 1), 1'b1);
    for (int p = 0; p < 4; p++) expect_beat(2'(p), mk(p, 0), 1'b1);
    expect_beat(2'd0, mk(0, 1), 1'b1);
    @(negedge clk);
    check("t1_first_ready", 32'(dataIn_ready), 32'b0001);
    check("t1_latency_empty", 32'(dataOut_valid), 32'd0);
    @(negedge clk);
    check("t1_latency_valid", 32'(dataOut_valid), 32'd1);
    check("t1_second_ready", 32'(dataIn_ready), 32'b0010);
    wait_drain("t1");
    check("t1_beat_count", 32'(out_cyc.size()), 32'd5);
    if (out_cyc.size() >= 5) check("t1_throughput", 32'(out_cyc[4] - out_cyc[0]), 32'd4);

    // Port 2 four-beat packet with a 2-cycle bubble; ports 0 and 3 wait; ptr is 1 here
    phase = 2;
    viol = 0;
    send(2, mk(2, 10), 1'b0);
    send(2, mk(2, 11), 1'b0);
    gap(2);
    gap(2);
    send(2, mk(2, 12), 1'b0);
    send(2, mk(2, 13), 1'b1);
    send(0, mk(0, 10), 1'b1);
    send(3, mk(3, 10), 1'b1);
    expect_beat(2'd2, mk(2, 10), 1'b0);
    expect_beat(2'd2, mk(2, 11), 1'b0);
    expect_beat(2'd2, mk(2, 12), 1'b0);
    expect_beat(2'd2, mk(2, 13), 1'b1);
    expect_beat(2'd3, mk(3, 10), 1'b1);
    expect_beat(2'd0, mk(0, 10), 1'b1);
    wait_drain("t2");
    phase = 0;
    check("t2_port0_blocked", 32'(viol), 32'd0);

    // Output stall for 3 cycles in the middle of a port 1 packet
    phase = 3;
    send(1, mk(1, 20), 1'b0);
    send(1, mk(1, 21), 1'b0);
    send(1, mk(1, 22), 1'b1);
    rdy_q.push_back(1'b1);
    rdy_q.push_back(1'b1);
    rdy_q.push_back(1'b0);
    rdy_q.push_back(1'b0);
    rdy_q.push_back(1'b0);
    expect_beat(2'd1, mk(1, 20), 1'b0);
    expect_beat(2'd1, mk(1, 21), 1'b0);
    expect_beat(2'd1, mk(1, 22), 1'b1);
    repeat (3) @(negedge clk);
    check("t3_stall_ready", 32'(dataIn_ready), 32'd0);
    check("t3_stall_valid", 32'(dataOut_valid), 32'd1);
    check_d("t3_stall_payload", dataOut_payload, mk(1, 21));
    wait_drain("t3");

    // Only port 3: two back-to-back 2-beat packets, ptr wraps to 0 between them
    phase = 4;
    out_cyc.delete();
    send(3, mk(3, 30), 1'b0);
    send(3, mk(3, 31), 1'b1);
    send(3, mk(3, 32), 1'b0);
    send(3, mk(3, 33), 1'b1);
    expect_beat(2'd3, mk(3, 30), 1'b0);
    expect_beat(2'd3, mk(3, 31), 1'b1);
    expect_beat(2'd3, mk(3, 32), 1'b0);
    expect_beat(2'd3, mk(3, 33), 1'b1);
    wait_drain("t4");
    check("t4_beat_count", 32'(out_cyc.size()), 32'd4);
    if (out_cyc.size() >= 4) check("t4_no_idle", 32'(out_cyc[3] - out_cyc[0]), 32'd3);

    // Reset in the middle of a port 2 packet after port 0 moved ptr to 1
    phase = 5;
    send(0, mk(0, 40), 1'b1);
    send(2, mk(2, 40), 1'b0);
    send(2, mk(2, 41), 1'b0);
    send(2, mk(2, 42), 1'b1);
    expect_beat(2'd0, mk(0, 40), 1'b1);
    expect_beat(2'd2, mk(2, 40), 1'b0);
    seq = 200;
    while (exp_q.size() != 0 && seq > 0) begin
      @(posedge clk);
      seq--;
    end
    check("t5_pre_reset_beats", 32'(exp_q.size()), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_async_valid", 32'(dataOut_valid), 32'd0);
    check("t5_async_last", 32'(dataOut_last), 32'd0);
    check("t5_async_source", 32'(dataOut_source), 32'd0);
    for (int p = 0; p < 4; p++) begin
      pq[p].delete();
      shown[p] = 1'b0;
    end
    exp_q.delete();
    dataIn_valid = '0;
    dataIn_last = '0;
    xfer_s = '0;
    #1;
    check("t5_reset_ready", 32'(dataIn_ready), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    send(1, mk(1, 50), 1'b1);
    send(0, mk(0, 50), 1'b1);
    expect_beat(2'd0, mk(0, 50), 1'b1);
    expect_beat(2'd1, mk(1, 50), 1'b1);
    wait_drain("t5");

    // Randomized traffic: per-port order and packet integrity
    phase = 6;
    rand_mode = 1'b1;
    for (int p = 0; p < 4; p++) begin
      seq = 0;
      for (int k = 0; k < 50; k++) begin
        len = int'($urandom_range(1, 4));
        for (int j = 0; j < len; j++) begin
          if ($urandom_range(0, 3) == 0) gap(p);
          b.bubble = 1'b0;
          b.last = (j == len - 1);
          b.data = {$urandom, $urandom, 8'(p), 24'(seq), 32'(k)};
          pq[p].push_back(b);
          e.src = 2'(p); e.last = b.last; e.data = b.data;
          exp_port[p].push_back(e);
          seq++;
        end
      end
    end
    wait_drain("t6");
    rand_mode = 1'b0;
    phase = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stream_rr_arbiter.md
STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, default 128, payload width in bits.
REQ-002 Parameter: PORTS, fixed 4, number of input streams; source index width is 2.
REQ-003 Port: clk  input  1  single clock; all logic rising-edge.
REQ-004 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port: dataIn_valid  input  PORTS  per-port valid, bit i = port i.
REQ-006 Port: dataIn_ready  output  PORTS  per-port ready, bit i = port i.
REQ-007 Port: dataIn_payload  input  PORTS*DATA_WIDTH  port i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 Port: dataIn_last  input  PORTS  per-port end-of-packet flag.
REQ-009 Port: dataOut_valid  output  1  merged stream valid.
REQ-010 Port: dataOut_ready  input  1  merged stream ready.
REQ-011 Port: dataOut_payload  output  DATA_WIDTH  merged payload.
REQ-012 Port: dataOut_last  output  1  merged end-of-packet flag.
REQ-013 Port: dataOut_source  output  2  index of the port that supplied the current beat.

Function
REQ-014 The block SHALL merge four valid/ready packet streams into one stream, arbitrating round-robin at packet granularity.
REQ-015 A beat SHALL transfer on any interface when valid and ready are both 1 on the same rising edge.
REQ-016 FSM states SHALL be IDLE (no grant) and LOCKED (grant held by register gnt_idx).
REQ-017 In IDLE, the winner SHALL be the first port with valid=1 searching ptr, ptr+1, ... modulo 4; arbitration is combinational, with no idle cycle between grant and first beat.
REQ-018 IDLE -> LOCKED SHALL occur when the winner's first beat transfers with last=0; gnt_idx is loaded with the winner.
REQ-019 LOCKED SHALL persist across input bubbles (granted valid=0) and output stalls; no other port is granted while LOCKED.
REQ-020 LOCKED -> IDLE SHALL occur on transfer of a granted beat with last=1; a single-beat packet (last=1 on its first beat) SHALL leave the FSM in IDLE.
REQ-021 On every packet-ending transfer, ptr SHALL be set to (granted index + 1) mod 4, so 3 wraps to 0.
REQ-022 Stage-accept SHALL be (!dataOut_valid || dataOut_ready).
REQ-023 dataIn_ready[i] SHALL be 1 only when port i is the current grantee (winner in IDLE, gnt_idx in LOCKED) and stage-accept=1; every other ready bit SHALL be 0.
REQ-024 The output SHALL be one register stage that latches payload, last and the source index on each input transfer.
REQ-025 Latency SHALL be 1 cycle from input transfer to dataOut_valid.
REQ-026 Throughput SHALL be one beat per clock when dataOut_ready=1.
REQ-027 When dataOut_ready=1 and no input transfers, dataOut_valid SHALL drop to 0.
REQ-028 When dataOut_valid=1 and dataOut_ready=0, dataOut_payload, dataOut_last and dataOut_source SHALL hold stable.
REQ-029 If no port is valid in IDLE, all dataIn_ready bits SHALL be 0 and ptr SHALL be unchanged.
REQ-030 Payload SHALL pass unmodified and bit-exact; no width conversion.

Reset
REQ-031 While reset_n=0 (asynchronous assertion, synchronous release is the integrator's duty): FSM=IDLE, ptr=0, gnt_idx=0, dataOut_valid=0, dataOut_last=0, dataOut_source=0.
REQ-032 The payload register SHALL NOT be reset.
REQ-033 Reset asserted mid-packet SHALL discard the lock and the output beat; after release, arbitration restarts from port 0.

Verification
REQ-034 All four ports valid with single-beat packets, dataOut_ready=1 -> dataOut_source sequence 0,1,2,3,0, one beat per clock, first output 1 cycle after first input transfer.
REQ-035 Port 2 sends a 4-beat packet with a 2-cycle bubble after beat 2 while port 0 is valid -> port 0 ready stays 0 until port 2's last beat transfers; next packet source=3 if port 3 is valid, else 0.
REQ-036 dataOut_ready=0 for 3 cycles mid-packet -> all dataIn_ready=0 after stage fills, held output stable, no beat lost or duplicated; payload scoreboard matches.
REQ-037 Only port 3 active, back-to-back packets -> ptr wraps to 0 and port 3 is re-granted with no idle cycle.
REQ-038 reset_n pulsed low mid-packet -> dataOut_valid=0 immediately (asynchronous); after release, with ports 1 and 0 both valid, port 0 is granted first.
REQ-039 Random valid/last/dataOut_ready for 10k cycles -> no packet interleaving on the output, per-port order preserved, and every ready bit is 0 except the grantee's.
